// File: rtl/pkt_upsizer_inj.sv
// Avalon-ST upsizer: packs IN_BYTES beats into OUT_BYTES words; packet starts are admitted by an LFSR/credit gate.
// Latency: two edges from word completion to out_valid. in_ready depends only on accumulator state, never on out_ready.
module pkt_upsizer_inj #(
  parameter int IN_BYTES    = 8,
  parameter int OUT_BYTES   = 64,
  parameter int RATE_THRESH = 65535,
  parameter int SEED        = 1,
  parameter int MAX_CREDIT  = 15,
  localparam int EW  = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1,
  localparam int OEW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic                   in_error,
  input  logic [8*IN_BYTES-1:0]  in_data,
  input  logic [EW-1:0]          in_empty,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   out_error,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OEW-1:0]         out_empty,
  input  logic                   out_ready,
  output logic [31:0]            o_pkt_count,
  output logic                   o_proto_err
);
  localparam int RATIO = OUT_BYTES / IN_BYTES;
  localparam int IW    = 8 * IN_BYTES;
  localparam int OW    = 8 * OUT_BYTES;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BW    = $clog2(OUT_BYTES + 1);
  localparam int CRW   = (MAX_CREDIT > 0) ? $clog2(MAX_CREDIT + 1) : 1;
  localparam logic [15:0] SEED_V = (16'(SEED) == 16'd0) ? 16'd1 : 16'(SEED);

  typedef enum logic {IDLE, PKT} state_t;
  state_t state, state_nxt;

  logic          acc_complete, acc_sop, acc_eop, acc_err, pkt_err;
  logic [CW-1:0] acc_cnt;
  logic [BW-1:0] acc_bytes;
  logic [OW-1:0] acc_data;
  logic [15:0]   lfsr, lfsr_nxt;
  logic [CRW-1:0] credit;

  logic in_hs, drop, start, proto, beat_take, closes;
  logic draw, gate_open, mv, pkt_start;
  int   valid_bytes;
  logic [IW-1:0] beat_dat;
  logic [OW-1:0] beat_wide, beat_shift;

  assign in_ready  = !acc_complete && !rst;
  assign in_hs     = in_valid && in_ready;
  assign beat_take = in_hs && !drop;
  assign closes    = beat_take && (in_eop || acc_cnt == CW'(RATIO - 1));

  assign lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign draw      = ({16'd0, lfsr} < 32'(RATE_THRESH)) && out_ready;
  assign gate_open = draw || (credit != '0);
  // Only the first word of a packet waits for the gate; continuation words flow freely.
  assign mv        = acc_complete && (!out_valid || out_ready) && (!acc_sop || gate_open);
  assign pkt_start = mv && acc_sop;

  always_comb begin
    state_nxt = state;
    drop      = 1'b0;
    start     = 1'b0;
    proto     = 1'b0;
    if (in_hs) begin
      if (state == IDLE) begin
        if (!in_sop) begin
          drop  = 1'b1;
          proto = 1'b1;
        end else begin
          start = 1'b1;
          if (!in_eop) state_nxt = PKT;
        end
      end else begin
        if (in_sop) proto = 1'b1;
        if (in_eop) state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    valid_bytes = in_eop ? (IN_BYTES - int'(in_empty)) : IN_BYTES;
    beat_dat    = in_eop ? (in_data & ({IW{1'b1}} << (int'(in_empty) * 8))) : in_data;
    beat_wide   = '0;
    beat_wide[OW-1 -: IW] = beat_dat;
    beat_shift  = beat_wide >> (IW * int'(acc_cnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= SEED_V;
      credit       <= '0;
      acc_complete <= 1'b0;
      acc_sop      <= 1'b0;
      acc_eop      <= 1'b0;
      acc_err      <= 1'b0;
      pkt_err      <= 1'b0;
      acc_cnt      <= '0;
      acc_bytes    <= '0;
      acc_data     <= '0;
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_error    <= 1'b0;
      out_data     <= '0;
      out_empty    <= '0;
      o_pkt_count  <= '0;
      o_proto_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      if (proto) o_proto_err <= 1'b1;

      if (draw && !pkt_start) begin
        if (credit != CRW'(MAX_CREDIT)) credit <= credit + 1'b1;
      end else if (pkt_start && !draw) begin
        if (credit != '0) credit <= credit - 1'b1;
      end

      if (out_valid && out_ready && out_eop) o_pkt_count <= o_pkt_count + 32'd1;

      if (mv) begin
        out_valid <= 1'b1;
        out_data  <= acc_data;
        out_sop   <= acc_sop;
        out_eop   <= acc_eop;
        out_error <= acc_err;
        out_empty <= OEW'(OUT_BYTES - int'(acc_bytes));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // mv and beat_take are exclusive: one needs a complete word, the other an open one.
      if (mv) begin
        acc_complete <= 1'b0;
        acc_sop      <= 1'b0;
        acc_eop      <= 1'b0;
        acc_err      <= 1'b0;
        acc_cnt      <= '0;
        acc_bytes    <= '0;
        acc_data     <= '0;
      end else if (beat_take) begin
        acc_data  <= acc_data | beat_shift;
        acc_cnt   <= closes ? '0 : acc_cnt + 1'b1;
        acc_bytes <= BW'(IN_BYTES * int'(acc_cnt) + valid_bytes);
        acc_eop   <= in_eop;
        acc_err   <= in_eop && ((pkt_err && !start) || in_error);
        pkt_err   <= in_eop ? 1'b0 : (((pkt_err && !start)) || in_error);
        if (start)  acc_sop      <= 1'b1;
        if (closes) acc_complete <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pkt_upsizer_inj.sv
// Bench for pkt_upsizer_inj: random packets against a byte-level word model, plus directed corner cases.
module tb_pkt_upsizer_inj;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic         err;
    logic [5:0]   empty;
  } word_t;

  logic clk, rst;
  logic in_valid, in_sop, in_eop, in_error, in_ready;
  logic [63:0] in_data;
  logic [2:0]  in_empty;
  logic out_valid, out_sop, out_eop, out_error, out_ready;
  logic [511:0] out_data;
  logic [5:0]   out_empty;
  logic [31:0]  o_pkt_count;
  logic         o_proto_err;

  logic g_in_valid, g_in_sop, g_in_eop, g_in_error, g_in_ready;
  logic [63:0] g_in_data;
  logic [2:0]  g_in_empty;
  logic g_out_valid, g_out_sop, g_out_eop, g_out_error, g_out_ready;
  logic [511:0] g_out_data;
  logic [5:0]   g_out_empty;
  logic [31:0]  g_pkt_count;
  logic         g_proto_err;

  int tests = 0, failed = 0, exp_pkts = 0;
  word_t got_q[$], exp_q[$];
  logic ready_val = 1'b1;
  logic rand_ready = 1'b0;

  pkt_upsizer_inj u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_error(in_error),
    .in_data(in_data), .in_empty(in_empty), .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_error(out_error),
    .out_data(out_data), .out_empty(out_empty), .out_ready(out_ready),
    .o_pkt_count(o_pkt_count), .o_proto_err(o_proto_err)
  );

  pkt_upsizer_inj #(.RATE_THRESH(0)) u_gate (
    .clk(clk), .rst(rst),
    .in_valid(g_in_valid), .in_sop(g_in_sop), .in_eop(g_in_eop), .in_error(g_in_error),
    .in_data(g_in_data), .in_empty(g_in_empty), .in_ready(g_in_ready),
    .out_valid(g_out_valid), .out_sop(g_out_sop), .out_eop(g_out_eop), .out_error(g_out_error),
    .out_data(g_out_data), .out_empty(g_out_empty), .out_ready(g_out_ready),
    .o_pkt_count(g_pkt_count), .o_proto_err(g_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // A handshake seen at a falling edge completes on the following rising edge.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        w.data = out_data; w.sop = out_sop; w.eop = out_eop;
        w.err = out_error; w.empty = out_empty;
        got_q.push_back(w);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference: packet bytes cut into 64-byte words, left-aligned, zero padded.
  function automatic void model_pkt(input bq_t b, input logic err);
    int n, nw, cnt;
    word_t x;
    n  = b.size();
    nw = (n + 63) / 64;
    for (int w = 0; w < nw; w++) begin
      x.data = '0;
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
        if (w * 64 + i < n) begin
          x.data[511 - 8*i -: 8] = b[w*64 + i];
          cnt++;
        end
      end
      x.sop   = (w == 0);
      x.eop   = (w == nw - 1);
      x.err   = (w == nw - 1) && err;
      x.empty = 6'(64 - cnt);
      exp_q.push_back(x);
    end
    exp_pkts++;
  endfunction

  function automatic bq_t mk_bytes(input int n, input bit seq);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(seq ? 8'(i) : 8'($urandom));
    return q;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic s, input logic e,
                            input logic [2:0] emp, input logic er, input int gap);
    int c;
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_empty = emp; in_error = er;
    c = 0;
    @(negedge clk);
    while (!in_ready && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 2000) begin
      tests++; failed++;
      $display("FAIL beat_accept: in_ready=%b after %0d cycles, required 1", in_ready, c);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
    if (gap > 0) step(gap);
  endtask

  task automatic send_pkt(input bq_t b, input int max_gap, input logic err, input logic mid_sop);
    int n, nb, errk, rem;
    logic [63:0] d;
    logic [2:0]  emp;
    n  = b.size();
    nb = (n + 7) / 8;
    errk = err ? $urandom_range(0, nb - 1) : -1;
    model_pkt(b, err);
    for (int k = 0; k < nb; k++) begin
      d = '0;
      for (int j = 0; j < 8; j++) if (k*8 + j < n) d[63 - 8*j -: 8] = b[k*8 + j];
      rem = n - 8*k;
      emp = (rem >= 8) ? 3'd0 : 3'(8 - rem);
      drive_beat(d, (k == 0) || (mid_sop && k == 1), k == nb - 1, emp, k == errk,
                 $urandom_range(0, max_gap));
    end
  endtask

  task automatic wait_words(input int n);
    int c;
    c = 0;
    while (got_q.size() < n && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (got_q.size() < n) begin
      tests++; failed++;
      $display("FAIL wait_words: got %0d output words, required %0d", got_q.size(), n);
    end
    step(1);
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
      failed++;
      $display("FAIL reset_ctrl: out_valid=%b in_ready=%b sop=%b eop=%b, required all 0",
               out_valid, in_ready, out_sop, out_eop);
    end
    tests++;
    if (o_pkt_count !== 32'd0 || o_proto_err !== 1'b0 || out_data !== '0 || out_empty !== 6'd0) begin
      failed++;
      $display("FAIL reset_stat: count=%0d proto_err=%b empty=%0d, required 0 0 0",
               o_pkt_count, o_proto_err, out_empty);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
    step(1);
  endtask

  task automatic test_pkt64;
    word_t g, e;
    send_pkt(mk_bytes(64, 1), 0, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("FAIL latency_early: out_valid=%b one cycle after completion, required 0", out_valid);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1) begin
      failed++;
      $display("FAIL latency_min: out_valid=%b two cycles after completion, required 1", out_valid);
    end
    wait_words(1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (g.sop !== 1'b1 || g.eop !== 1'b1 || g.empty !== 6'd0 ||
          g.data[511:504] !== 8'h00 || g.data[7:0] !== 8'h3F || g.data !== e.data) begin
        failed++;
        $display("FAIL pkt64: sop=%b eop=%b empty=%0d data=%h, required 1 1 0 data=%h",
                 g.sop, g.eop, g.empty, g.data, e.data);
      end
    end
    step(2);
    tests++;
    if (o_pkt_count !== 32'd1) begin
      failed++;
      $display("FAIL pkt64_count: o_pkt_count=%0d, required 1", o_pkt_count);
    end
  endtask

  task automatic test_pkt70;
    word_t g, e;
    send_pkt(mk_bytes(70, 1), 1, 1'b0, 1'b0);
    wait_words(2);
    for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (g !== e || (i == 1 && (g.empty !== 6'd58 || g.eop !== 1'b1))) begin
        failed++;
        $display("FAIL pkt70_word%0d: sop=%b eop=%b empty=%0d data=%h, required sop=%b eop=%b empty=%0d data=%h",
                 i, g.sop, g.eop, g.empty, g.data, e.sop, e.eop, e.empty, e.data);
      end
    end
    step(2);
    tests++;
    if (o_pkt_count !== 32'(exp_pkts)) begin
      failed++;
      $display("FAIL pkt70_count: o_pkt_count=%0d, required %0d", o_pkt_count, exp_pkts);
    end
  endtask

  task automatic test_backpressure;
    word_t g, e, first;
    int bad;
    ready_val = 1'b0;
    step(2);
    send_pkt(mk_bytes(128, 0), 0, 1'b0, 1'b0);
    first = exp_q[0];
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== first.data || out_sop !== 1'b1 ||
          out_eop !== 1'b0 || out_empty !== 6'd0 || in_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      failed++;
      $display("FAIL stall_hold: %0d unstable cycles (valid=%b sop=%b in_ready=%b), required 0",
               bad, out_valid, out_sop, in_ready);
    end
    step(1);
    ready_val = 1'b1;
    wait_words(2);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (g !== e) begin
        failed++;
        $display("FAIL stall_word: sop=%b eop=%b empty=%0d data=%h, required sop=%b eop=%b empty=%0d data=%h",
                 g.sop, g.eop, g.empty, g.data, e.sop, e.eop, e.empty, e.data);
      end
    end
    step(3);
    tests++;
    if (got_q.size() != 0 || exp_q.size() != 0) begin
      failed++;
      $display("FAIL stall_dup: %0d extra and %0d missing words, required 0 0", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random;
    word_t g, e;
    int nerr;
    rand_ready = 1'b1;
    for (int p = 0; p < 25; p++)
      send_pkt(mk_bytes($urandom_range(1, 200), 0), 2, 1'($urandom_range(0, 3) == 0), 1'b0);
    wait_words(exp_q.size());
    nerr = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (g !== e) begin
        failed++; nerr++;
        if (nerr < 4)
          $display("FAIL rand_word: sop=%b eop=%b err=%b empty=%0d data=%h, required sop=%b eop=%b err=%b empty=%0d data=%h",
                   g.sop, g.eop, g.err, g.empty, g.data, e.sop, e.eop, e.err, e.empty, e.data);
      end
    end
    rand_ready = 1'b0;
    ready_val = 1'b1;
    step(4);
    tests++;
    if (got_q.size() != 0 || o_pkt_count !== 32'(exp_pkts)) begin
      failed++;
      $display("FAIL rand_count: extra=%0d o_pkt_count=%0d, required 0 %0d", got_q.size(), o_pkt_count, exp_pkts);
    end
  endtask

  task automatic test_back_to_back;
    word_t g, e;
    int bad;
    for (int p = 0; p < 20; p++) send_pkt(mk_bytes($urandom_range(1, 16), 0), 0, 1'b0, 1'b0);
    wait_words(exp_q.size());
    bad = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      if (g !== e) bad++;
    end
    tests++;
    if (bad != 0 || exp_q.size() != 0) begin
      failed++;
      $display("FAIL b2b_words: %0d wrong, %0d missing, required 0 0", bad, exp_q.size());
    end
  endtask

  task automatic test_proto;
    word_t g, e;
    int cnt0;
    cnt0 = exp_pkts;
    drive_beat(64'hDEAD_BEEF_0011_2233, 1'b0, 1'b0, 3'd0, 1'b0, 0);
    step(20);
    tests++;
    if (got_q.size() != 0 || o_proto_err !== 1'b1 || o_pkt_count !== 32'(cnt0)) begin
      failed++;
      $display("FAIL proto_idle: outs=%0d proto_err=%b count=%0d, required 0 1 %0d",
               got_q.size(), o_proto_err, o_pkt_count, cnt0);
    end
    send_pkt(mk_bytes(40, 0), 0, 1'b0, 1'b1);
    wait_words(1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (g !== e) begin
        failed++;
        $display("FAIL proto_midsop: sop=%b eop=%b empty=%0d data=%h, required sop=%b eop=%b empty=%0d data=%h",
                 g.sop, g.eop, g.empty, g.data, e.sop, e.eop, e.empty, e.data);
      end
    end
  endtask

  task automatic test_reset_mid;
    word_t g, e;
    for (int k = 0; k < 3; k++)
      drive_beat({$urandom, $urandom}, k == 0, 1'b0, 3'd0, 1'b0, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    exp_pkts = 0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || o_proto_err !== 1'b0 || o_pkt_count !== 32'd0) begin
      failed++;
      $display("FAIL rst_mid_state: valid=%b proto_err=%b count=%0d, required 0 0 0",
               out_valid, o_proto_err, o_pkt_count);
    end
    step(1);
    send_pkt(mk_bytes(16, 0), 0, 1'b0, 1'b0);
    wait_words(1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (g !== e || g.empty !== 6'd48) begin
        failed++;
        $display("FAIL rst_mid_pkt: sop=%b eop=%b empty=%0d data=%h, required sop=1 eop=1 empty=48 data=%h",
                 g.sop, g.eop, g.empty, g.data, e.data);
      end
    end
  endtask

  task automatic test_gate;
    int c, seen, rdy;
    for (int k = 0; k < 2; k++) begin
      g_in_valid = 1'b1; g_in_sop = (k == 0); g_in_eop = (k == 1);
      g_in_data = {$urandom, $urandom}; g_in_empty = 3'd0;
      c = 0;
      @(negedge clk);
      while (!g_in_ready && c < 100) begin
        @(negedge clk);
        c++;
      end
      tests++;
      if (c >= 100) begin
        failed++;
        $display("FAIL gate_accept%0d: in_ready=%b, required 1", k, g_in_ready);
      end
      @(posedge clk);
      #1;
    end
    g_in_sop = 1'b1; g_in_eop = 1'b1;
    seen = 0; rdy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (g_out_valid !== 1'b0) seen++;
      if (g_in_ready !== 1'b0) rdy++;
    end
    g_in_valid = 1'b0;
    tests++;
    if (seen != 0 || rdy != 0) begin
      failed++;
      $display("FAIL gate_closed: out_valid cycles=%0d in_ready cycles=%0d, required 0 0", seen, rdy);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0; in_data = '0; in_empty = '0;
    g_in_valid = 1'b0; g_in_sop = 1'b0; g_in_eop = 1'b0; g_in_error = 1'b0;
    g_in_data = '0; g_in_empty = '0; g_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_pkt64();
    test_pkt70();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_proto();
    test_reset_mid();
    test_gate();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
